// File: rtl/iomem_cmd_master.sv
// iomem_cmd_master: turns one command from a valid/ready command port into a
// single picosoc iomem transaction and returns read data and status on a
// valid/ready response port.
// Ports:
//   sysclk, resetn                      clock, synchronous active-low reset
//   cmd_valid/cmd_ready                 command handshake (cmd_ready is combinational)
//   cmd_write, cmd_addr, cmd_wdata,     command payload
//   cmd_wstrb
//   rsp_valid/rsp_ready                 response handshake
//   rsp_rdata, rsp_error                read data, status (00 ok, 01 timeout, 10 misaligned)
//   iomem_valid, iomem_ready,           iomem initiator signals
//   iomem_wstrb, iomem_addr,
//   iomem_wdata, iomem_rdata
module iomem_cmd_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        sysclk,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_error,
  output logic        iomem_valid,
  input  logic        iomem_ready,
  output logic [3:0]  iomem_wstrb,
  output logic [31:0] iomem_addr,
  output logic [31:0] iomem_wdata,
  input  logic [31:0] iomem_rdata
);

  localparam int unsigned TIMER_W = 16;
  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_ALIGN   = 2'b10;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state, state_n;
  logic [TIMER_W-1:0] timer, timer_n;
  logic               write_q, write_n;
  logic               iomem_valid_n;
  logic [3:0]         iomem_wstrb_n;
  logic [31:0]        iomem_addr_n;
  logic [31:0]        iomem_wdata_n;
  logic               rsp_valid_n;
  logic [31:0]        rsp_rdata_n;
  logic [1:0]         rsp_error_n;

  // Only one command in flight: accept only while idle and out of reset.
  assign cmd_ready = resetn && (state == IDLE);

  // State and registered outputs.
  always_ff @(posedge sysclk) begin
    if (!resetn) begin
      state       <= IDLE;
      timer       <= '0;
      write_q     <= 1'b0;
      iomem_valid <= 1'b0;
      iomem_wstrb <= '0;
      iomem_addr  <= '0;
      iomem_wdata <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_error   <= ERR_OK;
    end else begin
      state       <= state_n;
      timer       <= timer_n;
      write_q     <= write_n;
      iomem_valid <= iomem_valid_n;
      iomem_wstrb <= iomem_wstrb_n;
      iomem_addr  <= iomem_addr_n;
      iomem_wdata <= iomem_wdata_n;
      rsp_valid   <= rsp_valid_n;
      rsp_rdata   <= rsp_rdata_n;
      rsp_error   <= rsp_error_n;
    end
  end

  // Next-state and next-output values.
  always_comb begin
    state_n       = state;
    timer_n       = timer;
    write_n       = write_q;
    iomem_valid_n = iomem_valid;
    iomem_wstrb_n = iomem_wstrb;
    iomem_addr_n  = iomem_addr;
    iomem_wdata_n = iomem_wdata;
    rsp_valid_n   = rsp_valid;
    rsp_rdata_n   = rsp_rdata;
    rsp_error_n   = rsp_error;

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          write_n = cmd_write;
          if (cmd_addr[1:0] != 2'b00) begin
            // Misaligned: answer directly, never touch the bus.
            state_n     = RESP;
            rsp_valid_n = 1'b1;
            rsp_rdata_n = '0;
            rsp_error_n = ERR_ALIGN;
          end else begin
            state_n       = BUS;
            iomem_valid_n = 1'b1;
            iomem_addr_n  = cmd_addr;
            iomem_wdata_n = cmd_wdata;
            iomem_wstrb_n = cmd_write ? cmd_wstrb : 4'b0000;
            timer_n       = '0;
          end
        end
      end

      BUS: begin
        // Ready takes priority over an expiring timer.
        if (iomem_ready) begin
          state_n       = RESP;
          iomem_valid_n = 1'b0;
          rsp_valid_n   = 1'b1;
          rsp_rdata_n   = write_q ? 32'h0 : iomem_rdata;
          rsp_error_n   = ERR_OK;
        end else if (timer == TIMER_LAST) begin
          state_n       = RESP;
          iomem_valid_n = 1'b0;
          rsp_valid_n   = 1'b1;
          rsp_rdata_n   = '0;
          rsp_error_n   = ERR_TIMEOUT;
        end else begin
          timer_n = timer + TIMER_W'(1);
        end
      end

      RESP: begin
        if (rsp_ready) begin
          state_n     = IDLE;
          rsp_valid_n = 1'b0;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_iomem_cmd_master.sv
// Directed bench for iomem_cmd_master with a GPIO-style registered-ready
// responder and a scripted responder that raises ready on a chosen bus cycle.
module tb_iomem_cmd_master;

  localparam int unsigned TMO = 8;
  localparam int unsigned NEVER = 16'hFFFF;

  logic        sysclk = 1'b0;
  logic        resetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_error;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  // Responder selection and state.
  logic        gpio_en;
  logic        gpio_ready;
  logic [31:0] gpio_rdata;
  logic [31:0] gpio;
  int unsigned ready_at;
  int unsigned bus_cyc;

  iomem_cmd_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .sysclk      (sysclk),
    .resetn      (resetn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .cmd_wstrb   (cmd_wstrb),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_error   (rsp_error),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_rdata (iomem_rdata)
  );

  always #5 sysclk = ~sysclk;

  // GPIO-style responder: registered one-cycle ready, reads return old value.
  always @(posedge sysclk) begin
    if (!resetn) begin
      gpio_ready <= 1'b0;
      gpio_rdata <= '0;
      gpio       <= '0;
    end else begin
      gpio_ready <= 1'b0;
      if (gpio_en && iomem_valid && !gpio_ready) begin
        gpio_ready <= 1'b1;
        gpio_rdata <= gpio;
        for (int b = 0; b < 4; b++)
          if (iomem_wstrb[b]) gpio[b*8 +: 8] <= iomem_wdata[b*8 +: 8];
      end
    end
  end

  // Number of completed bus cycles of the current iomem_valid window.
  always @(posedge sysclk) begin
    if (!resetn || !iomem_valid) bus_cyc <= 0;
    else                         bus_cyc <= bus_cyc + 1;
  end

  assign iomem_ready = gpio_en ? gpio_ready
                               : (iomem_valid && (bus_cyc == ready_at));
  assign iomem_rdata = gpio_en ? gpio_rdata : 32'hDEAD_BEEF;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge sysclk);
    #1;
  endtask

  // Offer a command, return edges from accept to rsp_valid, the number of
  // iomem_valid cycles and the strobes seen on the bus.
  task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, output int lat, output int vcyc,
                         output logic [3:0] wstrb_seen);
    int w;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_wstrb = wstrb;
    w = 0;
    while (!cmd_ready && w < 20) begin
      tick;
      w++;
    end
    if (w == 20) check("accept_timeout", 32'(w), 32'(0));
    tick;
    cmd_valid  = 1'b0;
    lat        = 0;
    vcyc       = 0;
    wstrb_seen = 4'hx;
    while (!rsp_valid && lat < 40) begin
      if (iomem_valid) begin
        if (vcyc == 0) wstrb_seen = iomem_wstrb;
        vcyc++;
      end
      tick;
      lat++;
    end
    if (lat == 40) check("rsp_timeout", 32'(lat), 32'(0));
  endtask

  int         lat;
  int         vcyc;
  logic [3:0] ws;

  initial begin
    #200000;
    $display("FAIL watchdog: got stuck expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn    = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_wstrb = '0;
    rsp_ready = 1'b0;
    gpio_en   = 1'b1;
    ready_at  = NEVER;
    tick;
    tick;
    check("rst_iomem_valid", 32'(iomem_valid), 32'(0));
    check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_error", 32'(rsp_error), 32'(0));
    check("rst_iomem_addr", iomem_addr, 32'h0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'(0));
    resetn = 1'b1;
    tick;
    check("idle_cmd_ready", 32'(cmd_ready), 32'(1));

    // GPIO write.
    run_cmd(1'b1, 32'h0300_0000, 32'h0000_00A5, 4'hF, lat, vcyc, ws);
    check("wr_latency", 32'(lat), 32'(2));
    check("wr_valid_cycles", 32'(vcyc), 32'(2));
    check("wr_wstrb", 32'(ws), 32'hF);
    check("wr_iomem_valid_low", 32'(iomem_valid), 32'(0));
    check("wr_error", 32'(rsp_error), 32'(0));
    check("wr_rdata", rsp_rdata, 32'h0);
    check("wr_leds", gpio, 32'h0000_00A5);
    check("wr_cmd_ready_busy", 32'(cmd_ready), 32'(0));
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    check("wr_rsp_drop", 32'(rsp_valid), 32'(0));
    check("wr_back_idle", 32'(cmd_ready), 32'(1));

    // Read-back.
    run_cmd(1'b0, 32'h0300_0000, 32'h1234_5678, 4'hF, lat, vcyc, ws);
    check("rd_wstrb", 32'(ws), 32'h0);
    check("rd_latency", 32'(lat), 32'(2));
    check("rd_rdata", rsp_rdata, 32'h0000_00A5);
    check("rd_error", 32'(rsp_error), 32'(0));
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;

    // Timeout with no responder.
    gpio_en  = 1'b0;
    ready_at = NEVER;
    run_cmd(1'b0, 32'h0300_0004, 32'h0, 4'h0, lat, vcyc, ws);
    check("tmo_valid_cycles", 32'(vcyc), 32'(8));
    check("tmo_latency", 32'(lat), 32'(8));
    check("tmo_error", 32'(rsp_error), 32'(1));
    check("tmo_rdata", rsp_rdata, 32'h0);
    check("tmo_iomem_valid_low", 32'(iomem_valid), 32'(0));
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;

    // Ready in the last cycle before timeout wins.
    ready_at = 7;
    run_cmd(1'b0, 32'h0300_0008, 32'h0, 4'h0, lat, vcyc, ws);
    check("last_valid_cycles", 32'(vcyc), 32'(8));
    check("last_error", 32'(rsp_error), 32'(0));
    check("last_rdata", rsp_rdata, 32'hDEAD_BEEF);
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;

    // Misaligned write, then response backpressure.
    ready_at = NEVER;
    run_cmd(1'b1, 32'h0300_0002, 32'hFFFF_FFFF, 4'hF, lat, vcyc, ws);
    check("mis_latency", 32'(lat), 32'(0));
    check("mis_error", 32'(rsp_error), 32'(2));
    check("mis_rdata", rsp_rdata, 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick;
      check($sformatf("bp_rsp_valid_%0d", i), 32'(rsp_valid), 32'(1));
      check($sformatf("bp_error_%0d", i), 32'(rsp_error), 32'(2));
      check($sformatf("bp_rdata_%0d", i), rsp_rdata, 32'h0);
      check($sformatf("bp_cmd_ready_%0d", i), 32'(cmd_ready), 32'(0));
      check($sformatf("bp_no_bus_%0d", i), 32'(iomem_valid), 32'(0));
    end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    check("mis_rsp_drop", 32'(rsp_valid), 32'(0));
    check("mis_cmd_ready", 32'(cmd_ready), 32'(1));

    // rsp_ready held high: response lasts one cycle.
    gpio_en   = 1'b1;
    rsp_ready = 1'b1;
    run_cmd(1'b0, 32'h0300_0000, 32'h0, 4'h0, lat, vcyc, ws);
    check("hold_rdata", rsp_rdata, 32'h0000_00A5);
    tick;
    check("hold_one_cycle", 32'(rsp_valid), 32'(0));
    rsp_ready = 1'b0;

    // Reset while the bus cycle is outstanding.
    gpio_en   = 1'b0;
    ready_at  = NEVER;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h0300_0000;
    tick;
    cmd_valid = 1'b0;
    tick;
    check("mid_bus_valid", 32'(iomem_valid), 32'(1));
    resetn = 1'b0;
    tick;
    check("mid_rst_iomem_valid", 32'(iomem_valid), 32'(0));
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'(0));
    resetn = 1'b1;
    tick;
    tick;
    check("post_rst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'(1));

    // Normal operation after reset (GPIO was cleared by reset).
    gpio_en = 1'b1;
    run_cmd(1'b1, 32'h0300_0000, 32'h0000_003C, 4'h1, lat, vcyc, ws);
    check("post_wr_latency", 32'(lat), 32'(2));
    check("post_wr_error", 32'(rsp_error), 32'(0));
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    run_cmd(1'b0, 32'h0300_0000, 32'h0, 4'h0, lat, vcyc, ws);
    check("post_rd_rdata", rsp_rdata, 32'h0000_003C);
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
